// File: rtl/contador_n.sv
// rtl/contador_n.sv - WIDTH-bit up/down/step/load counter with registered wrap flag
module contador_n #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    // Operands widened by one bit so the top bit of the result carries the carry/borrow.
    localparam logic [WIDTH:0] LP_ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] LP_STEP = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] r_q;
    logic             r_rco;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_next;
    logic             w_wrap;

    // Next count and wrap flag, derived only from the current count (load never wraps).
    always_comb begin
        w_ext  = {1'b0, r_q};
        w_next = w_ext;
        case (MODO)
            2'b00:   w_next = w_ext + LP_ONE;
            2'b01:   w_next = w_ext - LP_ONE;
            2'b10:   w_next = w_ext - LP_STEP;
            default: w_next = {1'b0, D};
        endcase
        w_wrap = w_next[WIDTH];
    end

    // Count and wrap flag update together on enabled edges; hold otherwise.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_q   <= '0;
            r_rco <= 1'b0;
        end else if (ENB) begin
            r_q   <= w_next[WIDTH-1:0];
            r_rco <= w_wrap;
        end
    end

    assign Q   = r_q;
    assign RCO = r_rco;

endmodule

// File: doc/contador_n.md
CONTADOR_N -- requirements
Module: contador_n

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 Parameter STEP, default 3: decrement used in mode 2'b10, legal range 1..(2^WIDTH)-1.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET_L  input  1  asynchronous, active-low reset.
REQ-005 ENB  input  1  count enable; low = hold all state.
REQ-006 MODO  input  2  operation select: 00 up by 1, 01 down by 1, 10 down by STEP, 11 parallel load.
REQ-007 D  input  WIDTH  parallel load value, used in mode 11 only.
REQ-008 Q  output  WIDTH  registered count value.
REQ-009 RCO  output  1  registered ripple-carry/borrow flag.

Function
REQ-010 Q and RCO SHALL each come from a register; no combinational path from any input to Q or RCO.
REQ-011 ENB=1, MODO=00: Q SHALL become (Q+1) mod 2^WIDTH on each edge.
REQ-012 ENB=1, MODO=01: Q SHALL become (Q-1) mod 2^WIDTH on each edge.
REQ-013 ENB=1, MODO=10: Q SHALL become (Q-STEP) mod 2^WIDTH on each edge, with modular wrap on borrow.
REQ-014 ENB=1, MODO=11: Q SHALL become D on each edge.
REQ-015 Next-state arithmetic SHALL use WIDTH+1 bits; the extra bit SHALL act as carry/borrow and SHALL NOT reach Q.
REQ-016 ENB=1: RCO SHALL be loaded on the same edge as Q, with 1 exactly when that edge wraps. Otherwise 0.
REQ-016a Wrap in mode 00: prior Q = all ones.
REQ-016b Wrap in mode 01: prior Q = 0.
REQ-016c Wrap in mode 10: prior Q < STEP.
REQ-017 Mode 11 SHALL always load RCO with 0, for any D value.
REQ-018 RCO SHALL therefore be high in the same cycle that Q shows the wrapped value. It stays high for one cycle unless the next enabled edge also wraps.
REQ-019 ENB=0: Q and RCO SHALL both hold their current values, including RCO=1.
REQ-020 A MODO change SHALL take effect on the first enabled edge after the change, with no extra latency. Next state SHALL be computed only from the current Q.
REQ-021 STEP=1: mode 10 SHALL behave exactly like mode 01, including RCO.
REQ-022 Q SHALL never hold X or Z after reset, for any MODO value. The case decode SHALL be fully specified and infer no latches.

Reset
REQ-023 RESET_L=0 SHALL force Q=0 and RCO=0 immediately, without waiting for CLK, regardless of ENB or MODO.
REQ-024 While RESET_L=0, state SHALL ignore CLK edges.
REQ-025 Reset release SHALL be synchronised externally. The first edge with RESET_L=1 and ENB=1 SHALL perform a normal update from Q=0.
REQ-026 Reset asserted mid-count or while RCO=1 SHALL clear both outputs. No partial update SHALL survive.

Verification (WIDTH=4, STEP=3 unless stated)
REQ-027 Reset, ENB=1, MODO=00, 16 edges: Q steps 1..15 then 0. RCO=1 only in the cycle Q=0.
REQ-028 Load D=0001 (MODO=11), then MODO=01 for 2 edges: Q=0, RCO=0; then Q=15, RCO=1; then RCO=0 on the next edge.
REQ-029 Load D=0010, then MODO=10 for one edge: Q=15, RCO=1. Next edge: Q=12, RCO=0.
REQ-030 Q=15, RCO=1 after wrap, then ENB=0 for 5 edges: Q=15 and RCO=1 held throughout. Then ENB=1, MODO=00: Q=0, RCO=1 (wrap again).
REQ-031 RESET_L pulsed low between clock edges while Q=9: Q=0 and RCO=0 before the next CLK edge. Counting resumes from 0.
REQ-032 WIDTH=8, STEP=5, load 3, MODO=10 for one edge: Q=254, RCO=1. Then load 255, MODO=00: Q=0, RCO=1.
